// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-addressed memory without byte enables;
// sub-word stores become read-modify-write. Define LSU_MISALIGN_EN to reject misaligned H/W accesses.
module lsu_rmw #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    localparam logic [29:0] WORD_LIM = 30'(MEM_WORDS);

    state_t      state, nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merge_q;
    logic        accept, bad_f3, bad_range, misalign, err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext, merged;

    assign accept    = req_valid && req_ready;
    assign bad_range = req_addr[31:2] >= WORD_LIM;

    always_comb begin
        bad_f3 = req_we & req_funct3[2];
        case (req_funct3)
            3'b011, 3'b110, 3'b111: bad_f3 = 1'b1;
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    always_comb begin
        misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    // Without the check, H drops addr[0] and W drops addr[1:0] (aligned down).
    assign misalign = 1'b0;
`endif

    assign err = bad_f3 | bad_range | misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (err)                          nxt = RESP;
                else if (!req_we)                 nxt = LOAD;
                else if (req_funct3[1:0] == 2'b10) nxt = WRITE;
                else                              nxt = RMW_RD;
            end
            LOAD:    nxt = RESP;
            RMW_RD:  nxt = WRITE;
            WRITE:   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        mem_we    = (state == WRITE) && we_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = 32'h0;
        if (state == WRITE)
            mem_wdata = (f3_q[1:0] == 2'b10) ? wdata_q : merged;
    end

    // Little-endian lane extraction for loads
    assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'h0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'h0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            merge_q   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (err) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end
            end
            case (state)
                LOAD: begin
                    rsp_rdata <= load_ext;
                    rsp_err   <= 1'b0;
                end
                RMW_RD: merge_q <= mem_rdata;
                WRITE: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit directly upstream of the word-addressed data memory (64 x 32-bit, combinational read, write on posedge clk when WE).
- Accepts one RV32I load/store per request (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives word-aligned memory accesses; sub-word stores are done as read-modify-write, because the memory has no byte enables.
- Returns sign/zero-extended load data and an error flag on a registered response pulse.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the downstream memory; word index >= MEM_WORDS is out of range

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept; high only in IDLE
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request rejected, qualified by rsp_valid
mem_addr  output  32  byte address to memory, always {word_idx,2'b00}
mem_wdata  output  32  write word to memory
mem_we  output  1  memory write enable
mem_rdata  input  32  combinational read word from memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all latched request fields cleared.
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Accept: a request is accepted when req_valid && req_ready. On accept, latch we, funct3, addr, wdata.
- Errors, checked at accept:
  - Illegal funct3: 011, 110, 111, or store with funct3[2]=1.
  - addr[31:2] >= MEM_WORDS.
  - Misalignment, only when the optional feature is enabled.
  - On error: IDLE -> RESP; rsp_err=1, rsp_rdata=0, no memory access, mem_we never asserted.
- Load: IDLE -> LOAD -> RESP -> IDLE.
  - In LOAD, mem_addr is driven and mem_rdata is sampled at the end of the cycle.
  - Byte/half is selected by addr[1:0] / addr[1], little-endian.
  - B and H are sign-extended; BU and HU are zero-extended.
  - Result is registered into rsp_rdata.
  - rsp_valid rises 2 cycles after the accept edge.
- SW: IDLE -> WRITE -> RESP.
  - In WRITE: mem_we=1, mem_wdata=latched wdata.
- SB/SH: IDLE -> RMW_RD -> WRITE -> RESP.
  - RMW_RD samples mem_rdata into a merge register.
  - WRITE drives the merge register with the selected byte/half lane replaced by wdata[7:0] / wdata[15:0]; other lanes are unchanged.
- mem_we: asserted only in WRITE, for exactly one cycle per store.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- rsp_rdata and rsp_err hold their values until the next RESP.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored, not queued.
- Reset mid-operation: returns to IDLE immediately. If reset occurs before WRITE, memory is untouched. A write already clocked is not undone.
- mem_addr holds the latched word address from accept until the next accept.

Optional Feature:
LSU_MISALIGN_EN
- Defined: the following are flagged as misaligned and take the error path with no memory access:
  - H/HU/SH with addr[0]=1.
  - W/SW with addr[1:0]!=0.
- Undefined: no misalignment check.
  - Halfword ignores addr[0].
  - Word ignores addr[1:0].
  - The access proceeds aligned down.

Test Plan:
- Memory word1=0xdeadbeef; SB addr 0x5 wdata 0x000000AA -> mem_we one pulse with mem_wdata 0xdeadaaef at mem_addr 0x4; rsp_valid 3 cycles after accept, rsp_err=0.
- Word0=0xdeadbeef:
  - LB 0x3 -> rsp_rdata 0xffffffde.
  - LBU 0x3 -> 0x000000de.
  - LH 0x2 -> 0xffffdead.
  - LHU 0x0 -> 0x0000beef.
  - Each response arrives 2 cycles after accept.
- SW addr 0x8 wdata 0x12345678 -> single mem_we cycle, mem_wdata 0x12345678; a following LW 0x8 returns 0x12345678.
- LW addr 0x100 (word 64) and funct3=011 -> rsp_err=1, rsp_rdata=0, 1 cycle after accept; mem_we stays 0.
- SH addr 0x2 held req_valid during busy -> only one accept, req_ready=0 until RESP+1. Pull rst_n low during RMW_RD -> mem_we never rises, word unchanged, outputs at reset values.
- LW addr 0x2:
  - With LSU_MISALIGN_EN -> rsp_err=1.
  - Without it -> returns word0 (0xdeadbeef).
